lv_pwm_intb_decode: RTL and testbench
=====================================

// Module: lv_pwm_intb_decode
// PURPOSE
//  LV-side decoder for the INTB code that the HV die inserts on the returned PWM channel.
//  Compares the received line with the LV gwave, delayed by the loop latency.
//  Classifies each deviation as glitch, INTB0 frame (1 seg ~g), INTB1 frame (~g,g,~g) or malformed.
//  Outputs the decoded HV intb_n level, an update strobe and a watchdog timeout.
// PARAMETERS
//  EXT_CYC_NUM  16  nominal segment length in clk cycles; equals PWM_INTB_EXT_CYC_NUM
//  TOL          2   +/- cycle tolerance on every segment length; TOL < EXT_CYC_NUM/2
//  LOOP_DLY     4   delay (cycles, >=1) applied to i_lv_pwm_gwave to form exp_g
//  SEG_CNT_W    $clog2(EXT_CYC_NUM+TOL+2)  segment counter width
// PORTS
//  i_clk             in   1  clock
//  i_rst_n           in   1  asynchronous active-low reset
//  i_pwm_intb_rcv    in   1  received PWM/INTB line, already synchronised
//  i_lv_pwm_gwave    in   1  gwave LV is sending to HV
//  i_wdgintb_en      in   1  watchdog check enable
//  i_wdgintb_config  in   2  index into WDG_INTB_TH
//  o_lv_intb_n       out  1  decoded HV intb_n level
//  o_intb_upd        out  1  1-cycle strobe per decoded frame (also for repeats)
//  o_frame_err       out  1  1-cycle strobe on malformed frame
//  o_wdg_timeout     out  1  no frame for 2*WDG_INTB_TH[cfg] cycles (sticky)
// BEHAVIOUR
//  Reset: o_lv_intb_n=1, o_intb_upd=0, o_frame_err=0, o_wdg_timeout=0, FSM=IDLE, delay line=0.
//  exp_g = i_lv_pwm_gwave delayed LOOP_DLY cycles; cnt = segment counter; L = EXT_CYC_NUM-TOL; H = EXT_CYC_NUM+TOL.
//  All outputs are registered; strobes fire the cycle after the deciding sample.
//  IDLE: rcv!=exp_g -> SEG0, g_lock<=exp_g, cnt<=1.
//  SEG0 (rcv==~g_lock): cnt++.
//   - If cnt==H with rcv still ~g_lock -> frame_err, go to IDLE.
//   - If rcv==g_lock and cnt<L -> glitch, go to IDLE silently.
//   - If rcv==g_lock and cnt>=L -> go to SEG1, cnt<=1.
//  SEG1 (rcv==g_lock): cnt++. Rules in priority order:
//   a) exp_g!=g_lock (PWM resumed) -> INTB0 decoded.
//   b) rcv==~g_lock and cnt<L -> frame_err, go to IDLE.
//   c) rcv==~g_lock and cnt>=L -> go to SEG2, cnt<=1.
//   d) cnt==H+1 -> INTB0 decoded.
//   INTB0 decoded: o_lv_intb_n<=0, upd strobe, go to IDLE.
//  SEG2 (rcv==~g_lock): cnt++.
//   - If rcv==g_lock before cnt==L -> frame_err, go to IDLE.
//   - If cnt==L -> o_lv_intb_n<=1, upd strobe, go to TAIL, cnt<=0.
//  TAIL: ignore mismatch until rcv==exp_g, then go to IDLE. If cnt reaches 2*TOL+1 first -> frame_err, go to IDLE.
//  A frame_err never changes o_lv_intb_n.
//  upd and frame_err are never set in the same cycle.
//  The counter saturates; it never wraps.
//  System constraint: LV gwave holds >= 3*EXT_CYC_NUM+LOOP_DLY cycles per phase.
//  i_wdgintb_en/config changes mid-frame do not affect the FSM.
// CONFIGURATION
//  Macro LV_PWM_INTB_WDG_CHK_EN.
//  Defined:
//   - wdg counter (WDG_CNT_W+1 bits) is cleared on o_intb_upd or when i_wdgintb_en=0; it increments otherwise.
//   - When the counter reaches (WDG_INTB_TH[cfg]<<1)-1, o_wdg_timeout<=1.
//   - o_wdg_timeout stays set until the next upd or until i_wdgintb_en=0.
//  Undefined: no counter; o_wdg_timeout tied 0; i_wdgintb_* unused.
// STRUCTURE
//  hv_param.svh (shared): WDG_INTB_TH[4], WDG_CNT_W, PWM_INTB_EXT_CYC_NUM, LV decode FSM state encodings.
//  Sub-module signal_delay #(DLY=LOOP_DLY) for the gwave delay line (reset 0); FSM and counters inline.
// TESTING (EXT=16, TOL=2, LOOP_DLY=4, exp_g=0 unless noted)
//  1 rcv=1x16, then 0 -> INTB0 decoded on cnt==19 of SEG1: o_lv_intb_n=0, one upd pulse, err=0.
//  2 rcv=1x16, 0x16, 1x16, 0 -> upd on 14th SEG2 cycle, o_lv_intb_n=1; TAIL exits, no err.
//  3 rcv=1x5 glitch; separately rcv=1x25 -> glitch: nothing; stuck: one frame_err at cnt 18, intb_n unchanged.
//  4 rcv=1x16, 0x8 with exp_g toggling 0->1 at SEG1 cnt 8 -> INTB0 decoded immediately, no err.
//  5 INTB1 frame with SEG1 only 10 cycles -> frame_err, o_lv_intb_n holds; next valid INTB0 decodes normally.
//  6 Macro on, en=1, cfg=0, no frames -> timeout at 2*WDG_INTB_TH[0]; valid frame clears it; rst_n low mid-SEG1 -> all reset values.

Source files
------------

// File: rtl/lv_pwm_intb_decode_pkg.sv
// Shared constants and types for the LV-side PWM/INTB decoder.
//   PWM_INTB_EXT_CYC_NUM : nominal INTB segment length (clk cycles), shared with the HV encoder
//   WDG_CNT_W            : width of one watchdog threshold entry
//   WDG_INTB_TH          : watchdog thresholds selected by i_wdgintb_config
//   lv_dec_state_e       : decode FSM state encodings
package lv_pwm_intb_decode_pkg;

  localparam int unsigned PWM_INTB_EXT_CYC_NUM = 16;
  localparam int unsigned WDG_CNT_W            = 9;

  localparam logic [WDG_CNT_W-1:0] WDG_INTB_TH [4] = '{
    9'd50, 9'd100, 9'd200, 9'd400
  };

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEG0 = 3'd1,
    ST_SEG1 = 3'd2,
    ST_SEG2 = 3'd3,
    ST_TAIL = 3'd4
  } lv_dec_state_e;

endpackage

// File: rtl/lv_pwm_intb_decode_signal_delay.sv
// Fixed-latency delay line for a single-bit signal (reset value 0).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   sig_in         : signal to delay
//   sig_out        : sig_in delayed by DLY clock cycles (DLY >= 1)
module lv_pwm_intb_decode_signal_delay #(
  parameter int unsigned DLY = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic sig_in,
  output logic sig_out
);

  logic [DLY-1:0] sr;

  // Shift register; the concatenation drops the oldest bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sr <= '0;
    else          sr <= DLY'({sr, sig_in});
  end

  assign sig_out = sr[DLY-1];

endmodule

// File: rtl/lv_pwm_intb_decode.sv
// LV-side decoder for the INTB code inserted by the HV die on the returned PWM line.
// The received line is compared with the LV gwave delayed by the loop latency (exp_g);
// deviations are classified as glitch, INTB0 frame (one inverted segment), INTB1 frame
// (inverted, normal, inverted segments) or malformed frame.
// Optional watchdog: define LV_PWM_INTB_WDG_CHK_EN.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_pwm_intb_rcv     : received PWM/INTB line (already synchronised)
//   i_lv_pwm_gwave     : gwave LV is sending to HV
//   i_wdgintb_en       : watchdog enable
//   i_wdgintb_config   : watchdog threshold select
//   o_lv_intb_n        : decoded HV intb_n level
//   o_intb_upd         : 1-cycle strobe per decoded frame
//   o_frame_err        : 1-cycle strobe per malformed frame
//   o_wdg_timeout      : sticky watchdog timeout
module lv_pwm_intb_decode
  import lv_pwm_intb_decode_pkg::*;
#(
  parameter int unsigned EXT_CYC_NUM = PWM_INTB_EXT_CYC_NUM,
  parameter int unsigned TOL         = 2,
  parameter int unsigned LOOP_DLY    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pwm_intb_rcv,
  input  logic       i_lv_pwm_gwave,
  input  logic       i_wdgintb_en,
  input  logic [1:0] i_wdgintb_config,
  output logic       o_lv_intb_n,
  output logic       o_intb_upd,
  output logic       o_frame_err,
  output logic       o_wdg_timeout
);

  localparam int unsigned SEG_CNT_W = $clog2(EXT_CYC_NUM + TOL + 2);

  localparam logic [SEG_CNT_W-1:0] CNT_ONE  = SEG_CNT_W'(1);
  localparam logic [SEG_CNT_W-1:0] CNT_L    = SEG_CNT_W'(EXT_CYC_NUM - TOL);
  localparam logic [SEG_CNT_W-1:0] CNT_H    = SEG_CNT_W'(EXT_CYC_NUM + TOL);
  localparam logic [SEG_CNT_W-1:0] CNT_H1   = SEG_CNT_W'(EXT_CYC_NUM + TOL + 1);
  localparam logic [SEG_CNT_W-1:0] CNT_TAIL = SEG_CNT_W'(2 * TOL + 1);
  localparam logic [SEG_CNT_W-1:0] CNT_MAX  = '1;

  lv_dec_state_e        state, state_nxt;
  logic [SEG_CNT_W-1:0] cnt, cnt_nxt, cnt_inc_c;
  logic                 g_lock, g_lock_nxt;
  logic                 intb_n_nxt, upd_nxt, err_nxt;
  logic                 exp_g;
  logic                 rcv_inv_c;

  // Loop-latency compensation for the gwave reference.
  lv_pwm_intb_decode_signal_delay #(
    .DLY (LOOP_DLY)
  ) u_gwave_dly (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .sig_in  (i_lv_pwm_gwave),
    .sig_out (exp_g)
  );

  // Saturating segment counter increment.
  assign cnt_inc_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  // Line currently opposite to the gwave level captured at frame start.
  assign rcv_inv_c = (i_pwm_intb_rcv != g_lock);

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      g_lock      <= 1'b0;
      o_lv_intb_n <= 1'b1;
      o_intb_upd  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      g_lock      <= g_lock_nxt;
      o_lv_intb_n <= intb_n_nxt;
      o_intb_upd  <= upd_nxt;
      o_frame_err <= err_nxt;
    end
  end

  // Frame classification.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    g_lock_nxt = g_lock;
    intb_n_nxt = o_lv_intb_n;
    upd_nxt    = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_pwm_intb_rcv != exp_g) begin
          state_nxt  = ST_SEG0;
          g_lock_nxt = exp_g;
          cnt_nxt    = CNT_ONE;
        end
      end
      ST_SEG0: begin
        if (rcv_inv_c) begin
          if (cnt >= CNT_H) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt_inc_c;
          end
        end else if (cnt < CNT_L) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_SEG1;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_SEG1: begin
        // Resumed PWM ends an INTB0 frame early; otherwise wait for SEG2 or timeout.
        if (exp_g != g_lock) begin
          intb_n_nxt = 1'b0;
          upd_nxt    = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (rcv_inv_c) begin
          if (cnt < CNT_L) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_SEG2;
            cnt_nxt   = CNT_ONE;
          end
        end else if (cnt >= CNT_H1) begin
          intb_n_nxt = 1'b0;
          upd_nxt    = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          cnt_nxt = cnt_inc_c;
        end
      end
      ST_SEG2: begin
        if (cnt >= CNT_L) begin
          intb_n_nxt = 1'b1;
          upd_nxt    = 1'b1;
          state_nxt  = ST_TAIL;
          cnt_nxt    = '0;
        end else if (!rcv_inv_c) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_inc_c;
        end
      end
      ST_TAIL: begin
        // Remainder of the last segment, bounded by the tolerance window.
        if (i_pwm_intb_rcv == exp_g) begin
          state_nxt = ST_IDLE;
        end else if (cnt_inc_c >= CNT_TAIL) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_inc_c;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef LV_PWM_INTB_WDG_CHK_EN
  localparam int unsigned WDG_W = WDG_CNT_W + 1;

  logic [WDG_W-1:0] wdg_cnt;
  logic [WDG_W-1:0] wdg_lim_c;

  assign wdg_lim_c = (WDG_W'(WDG_INTB_TH[i_wdgintb_config]) << 1) - WDG_W'(1);

  // Frame-absence watchdog; cleared by any decoded frame or by disabling.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdg_cnt       <= '0;
      o_wdg_timeout <= 1'b0;
    end else if (!i_wdgintb_en || o_intb_upd) begin
      wdg_cnt       <= '0;
      o_wdg_timeout <= 1'b0;
    end else begin
      if (wdg_cnt != '1) wdg_cnt <= wdg_cnt + WDG_W'(1);
      if (wdg_cnt >= wdg_lim_c) o_wdg_timeout <= 1'b1;
    end
  end
`else
  logic unused_wdg;
  assign unused_wdg    = ^{i_wdgintb_en, i_wdgintb_config};
  assign o_wdg_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lv_pwm_intb_decode.sv
// Self-checking bench for lv_pwm_intb_decode (EXT=16, TOL=2, LOOP_DLY=4).
// Expected strobes (kind, level, sample index) are queued while the deciding
// sample is driven and matched by a monitor when the strobe appears.
module tb_lv_pwm_intb_decode;
  import lv_pwm_intb_decode_pkg::*;

  localparam int EV_UPD = 1;
  localparam int EV_ERR = 2;
`ifdef LV_PWM_INTB_WDG_CHK_EN
  localparam logic WDG_ON = 1'b1;
`else
  localparam logic WDG_ON = 1'b0;
`endif

  typedef struct {
    int   kind;
    logic lvl;
    int   at;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rcv;
  logic       gw;
  logic       wdg_en;
  logic [1:0] wdg_cfg;
  logic       lv_intb_n, intb_upd, frame_err, wdg_timeout;

  int   cyc = 0;
  int   last_s = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic exp_lvl = 1'b1;
  evt_t sb[$];
  evt_t mon_e;
  int   s0;

  lv_pwm_intb_decode dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_pwm_intb_rcv   (rcv),
    .i_lv_pwm_gwave   (gw),
    .i_wdgintb_en     (wdg_en),
    .i_wdgintb_config (wdg_cfg),
    .o_lv_intb_n      (lv_intb_n),
    .o_intb_upd       (intb_upd),
    .o_frame_err      (frame_err),
    .o_wdg_timeout    (wdg_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive rcv/gwave for n samples; last_s tracks the sample index of the last one.
  task automatic drvg(input logic r, input logic g, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rcv    = r;
      gw     = g;
      last_s = cyc + 1;
    end
  endtask

  task automatic drv(input logic r, input int n);
    drvg(r, gw, n);
  endtask

  // Queue a strobe expected right after the most recently driven sample.
  task automatic expect_evt(input int kind, input logic lvl);
    evt_t e;
    if (kind == EV_UPD) exp_lvl = lvl;
    e.kind = kind;
    e.lvl  = exp_lvl;
    e.at   = last_s;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    drv(rcv, 4);
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Strobe monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (intb_upd || frame_err)) begin
      chk("upd_err_excl", 32'(intb_upd & frame_err), 32'd0);
      if (sb.size() == 0) begin
        chk("spurious_evt", {29'd0, intb_upd, frame_err, lv_intb_n}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("evt_kind", intb_upd ? 32'(EV_UPD) : 32'(EV_ERR), 32'(mon_e.kind));
        chk("evt_cycle", 32'(cyc), 32'(mon_e.at));
        chk("evt_level", 32'(lv_intb_n), 32'(mon_e.lvl));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    rcv     = 1'b0;
    gw      = 1'b0;
    wdg_en  = 1'b0;
    wdg_cfg = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_intb_n", 32'(lv_intb_n), 32'd1);
    chk("rst_upd", 32'(intb_upd), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_wdg", 32'(wdg_timeout), 32'd0);
    rst_n = 1'b1;
    drv(1'b0, 10);

    // INTB0: one 16-cycle inverted segment, SEG1 times out on its 20th sample.
    drv(1'b1, 16); drv(1'b0, 20); expect_evt(EV_UPD, 1'b0);
    drv(1'b0, 10); drain("s1_drain");

    // INTB1: decode on 15th sample of the third segment, tail exits cleanly.
    drv(1'b1, 16); drv(1'b0, 16); drv(1'b1, 15); expect_evt(EV_UPD, 1'b1);
    drv(1'b1, 1); drv(1'b0, 10); drain("s2_drain");

    // Short glitch: nothing reported.
    drv(1'b1, 5); drv(1'b0, 25); drain("s3a_drain");
    // Stuck line: error on the 19th inverted sample, then a harmless re-glitch.
    drv(1'b1, 19); expect_evt(EV_ERR, 1'b0);
    drv(1'b1, 6); drv(1'b0, 25); drain("s3b_drain");
    chk("s3_lvl_hold", 32'(lv_intb_n), 32'd1);

    // INTB1 with a 10-cycle SEG1 is malformed; a following INTB0 still decodes.
    drv(1'b1, 16); drv(1'b0, 10); drv(1'b1, 1); expect_evt(EV_ERR, 1'b0);
    drv(1'b1, 4); drv(1'b0, 30); drain("s5a_drain");
    chk("s5_lvl_hold", 32'(lv_intb_n), 32'd1);
    drv(1'b1, 16); drv(1'b0, 20); expect_evt(EV_UPD, 1'b0);
    drv(1'b0, 10); drain("s5b_drain");

    // Third segment too short (8 cycles) is malformed.
    drv(1'b1, 16); drv(1'b0, 16); drv(1'b1, 8); drv(1'b0, 1); expect_evt(EV_ERR, 1'b0);
    drv(1'b0, 20); drain("s8_drain");
    chk("s8_lvl_hold", 32'(lv_intb_n), 32'd0);

    // Segment length boundaries: 13 is a glitch, 14 and 18 are accepted.
    drv(1'b1, 13); drv(1'b0, 25); drain("bnd13_drain");
    drv(1'b1, 18); drv(1'b0, 16); drv(1'b1, 15); expect_evt(EV_UPD, 1'b1);
    drv(1'b1, 1); drv(1'b0, 10); drain("bnd18_drain");
    drv(1'b1, 14); drv(1'b0, 20); expect_evt(EV_UPD, 1'b0);
    drv(1'b0, 10); drain("bnd14_drain");

    // Overlong third segment: decode, then tail error after 2*TOL+1 extra samples.
    drv(1'b1, 16); drv(1'b0, 16); drv(1'b1, 15); expect_evt(EV_UPD, 1'b1);
    drv(1'b1, 5); expect_evt(EV_ERR, 1'b0);
    drv(1'b1, 5); drv(1'b0, 20); drain("s9_drain");

    // PWM resumes during SEG1 (exp_g rises at SEG1 cnt 8): immediate INTB0.
    drv(1'b1, 16); drv(1'b0, 4); drvg(1'b0, 1'b1, 4); drvg(1'b1, 1'b1, 1);
    expect_evt(EV_UPD, 1'b0);
    drv(1'b1, 60); drain("s4_drain");

    // INTB1 with gwave high (inverted polarity), then return gwave low.
    drv(1'b0, 16); drv(1'b1, 16); drv(1'b0, 15); expect_evt(EV_UPD, 1'b1);
    drv(1'b0, 1); drv(1'b1, 10);
    drvg(1'b1, 1'b0, 4); drv(1'b0, 60); drain("s7_drain");

    // Another INTB0 so the watchdog section starts from level 0.
    drv(1'b1, 16); drv(1'b0, 20); expect_evt(EV_UPD, 1'b0);
    drv(1'b0, 10); drain("pre_wdg_drain");

    // Watchdog: enable with cfg 0 and no frames.
    @(negedge clk);
    wdg_en  = 1'b1;
    wdg_cfg = 2'd0;
    s0      = cyc + 1;
    repeat (2 * int'(WDG_INTB_TH[0]) - 1) @(negedge clk);
    chk("wdg_early", 32'(wdg_timeout), 32'd0);
    @(negedge clk);
    chk("wdg_fire", 32'(wdg_timeout), 32'(WDG_ON));
    chk("wdg_fire_cyc", 32'(cyc - s0 + 1), 32'(2 * int'(WDG_INTB_TH[0])));
    drv(1'b0, 20);
    chk("wdg_sticky", 32'(wdg_timeout), 32'(WDG_ON));
    drv(1'b1, 16); drv(1'b0, 20); expect_evt(EV_UPD, 1'b0);
    drv(1'b0, 3);
    chk("wdg_clear", 32'(wdg_timeout), 32'd0);
    drain("wdg_drain");

    // Reset in the middle of SEG1.
    drv(1'b1, 16); drv(1'b0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_intb_n", 32'(lv_intb_n), 32'd1);
    chk("mid_rst_upd", 32'(intb_upd), 32'd0);
    chk("mid_rst_err", 32'(frame_err), 32'd0);
    chk("mid_rst_wdg", 32'(wdg_timeout), 32'd0);
    wdg_en  = 1'b0;
    exp_lvl = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drv(1'b0, 30); drain("post_rst_quiet");
    drv(1'b1, 16); drv(1'b0, 20); expect_evt(EV_UPD, 1'b0);
    drv(1'b0, 10); drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
